// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled 2-of-3 majority per bit, one-byte holding
// register with a level data_valid, one-clk framing error pulse and sticky overrun.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_tick,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       read,
  output logic       busy,
  output logic       framing_err,
  output logic       overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;
  localparam logic [CW-1:0] C_LO  = CW'(M - 1);
  localparam logic [CW-1:0] C_MID = CW'(M);
  localparam logic [CW-1:0] C_HI  = CW'(M + 1);
  localparam logic [CW-1:0] C_END = CW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic          rx_meta, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          smp_lo, smp_mid;
  logic          accept;
  logic          vote;

  // Third sample is the live synchronized line on the decision tick.
  assign vote = (smp_lo & smp_mid) | (smp_lo & rx_s) | (smp_mid & rx_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      smp_lo      <= 1'b1;
      smp_mid     <= 1'b1;
      busy        <= 1'b0;
      framing_err <= 1'b0;
      accept      <= 1'b0;
    end else begin
      framing_err <= 1'b0;
      accept      <= 1'b0;
      if (sample_tick) begin
        if (state != IDLE) begin
          cnt <= (cnt == C_END) ? '0 : cnt + 1'b1;
          if (cnt == C_LO)  smp_lo  <= rx_s;
          if (cnt == C_MID) smp_mid <= rx_s;
        end
        unique case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          START: begin
            if (cnt == C_HI && vote) begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else if (cnt == C_END) begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
          DATA: begin
            if (cnt == C_HI) shreg <= {vote, shreg[7:1]};
            if (cnt == C_END) begin
              if (bit_idx == 3'd7) state <= STOP;
              bit_idx <= bit_idx + 1'b1;
            end
          end
          STOP: begin
            // Leave at the stop decision so the next start edge is not missed.
            if (cnt == C_HI) begin
              state       <= IDLE;
              cnt         <= '0;
              busy        <= 1'b0;
              accept      <= vote;
              framing_err <= ~vote;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // A read in the accept clk frees the register, so the new byte lands cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (accept) begin
      if (!data_valid || read) begin
        data       <= shreg;
        data_valid <= 1'b1;
        overrun    <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (read && data_valid) begin
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule
